// File: rtl/bin_median3x3.sv
// 3x3 majority filter for a binary video mask with sync re-alignment; latency H_SIZE+2.
// Optional BIN_MORPH_MODE_EN adds a per-sample mode input (median/erode/dilate/bypass).
module bin_median3x3 #(
    parameter int unsigned H_SIZE   = 1650,
    parameter int unsigned MASK_BIT = 0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef BIN_MORPH_MODE_EN
    input  logic [1:0]  mode,
`endif
    input  logic        de_in,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [23:0] pixel_in,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic [23:0] pixel_out
);

    localparam int unsigned LAT   = H_SIZE + 2;
    localparam int unsigned DEPTH = H_SIZE - 2;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(LAT);
`ifdef BIN_MORPH_MODE_EN
    localparam int unsigned CTW   = 6;
`else
    localparam int unsigned CTW   = 4;
`endif

    // Centre-row tag layout: [0]=sample, [1]=vs, [2]=hs, [3]=de, [5:4]=mode when enabled.
    logic [CTW-1:0] w_in;
    logic           w_unused_pix;

`ifdef BIN_MORPH_MODE_EN
    assign w_in = {mode, de_in, h_sync_in, v_sync_in, pixel_in[MASK_BIT] & de_in};
`else
    assign w_in = {de_in, h_sync_in, v_sync_in, pixel_in[MASK_BIT] & de_in};
`endif
    assign w_unused_pix = ^pixel_in;

    logic [CTW-1:0] r_lb1 [DEPTH];
    logic           r_lb2 [DEPTH];
    logic [AW-1:0]  r_ptr;
    logic [CTW-1:0] w_lb1_rd;
    logic           w_lb2_rd;

    logic [CTW-1:0] r_row0_0, r_row0_1;
    logic           r_row0_2;
    logic [CTW-1:0] r_row1_0, r_row1_1;
    logic           r_row1_2;
    logic           r_row2_0, r_row2_1, r_row2_2;
    logic [CW-1:0]  r_warm;

    // Line delays: read-before-write at a shared pointer gives exactly DEPTH clocks of delay.
    assign w_lb1_rd = r_lb1[r_ptr];
    assign w_lb2_rd = r_lb2[r_ptr];

    always_ff @(posedge clk) begin
        r_lb1[r_ptr] <= r_row0_1;
        r_lb2[r_ptr] <= r_row1_1[0];
    end

    // Window taps plus ring pointer; row spacing is exactly H_SIZE samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_row0_0 <= '0;
            r_row0_1 <= '0;
            r_row0_2 <= 1'b0;
            r_row1_0 <= '0;
            r_row1_1 <= '0;
            r_row1_2 <= 1'b0;
            r_row2_0 <= 1'b0;
            r_row2_1 <= 1'b0;
            r_row2_2 <= 1'b0;
        end else begin
            r_ptr    <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
            r_row0_0 <= w_in;
            r_row0_1 <= r_row0_0;
            r_row0_2 <= r_row0_1[0];
            r_row1_0 <= w_lb1_rd;
            r_row1_1 <= r_row1_0;
            r_row1_2 <= r_row1_1[0];
            r_row2_0 <= w_lb2_rd;
            r_row2_1 <= r_row2_0;
            r_row2_2 <= r_row2_1;
        end
    end

    logic [3:0] w_sum;
    logic       w_hit;

    assign w_sum = 4'(r_row0_0[0]) + 4'(r_row0_1[0]) + 4'(r_row0_2)
                 + 4'(r_row1_0[0]) + 4'(r_row1_1[0]) + 4'(r_row1_2)
                 + 4'(r_row2_0)    + 4'(r_row2_1)    + 4'(r_row2_2);

`ifdef BIN_MORPH_MODE_EN
    always_comb begin
        w_hit = 1'b0;
        case (r_row1_1[5:4])
            2'd0:    w_hit = (w_sum >= 4'd5);
            2'd1:    w_hit = (w_sum == 4'd9);
            2'd2:    w_hit = (w_sum != 4'd0);
            default: w_hit = r_row1_1[0];
        endcase
    end
`else
    assign w_hit = (w_sum >= 4'd5);
`endif

    // Warm-up gate and output register; outputs stay 0 until the pipeline has refilled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_warm     <= '0;
            de_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            pixel_out  <= '0;
        end else begin
            if (r_warm != CW'(LAT - 1)) begin
                r_warm     <= r_warm + CW'(1);
                de_out     <= 1'b0;
                h_sync_out <= 1'b0;
                v_sync_out <= 1'b0;
                pixel_out  <= '0;
            end else begin
                de_out     <= r_row1_1[3];
                h_sync_out <= r_row1_1[2];
                v_sync_out <= r_row1_1[1];
                pixel_out  <= (r_row1_1[3] & w_hit) ? 24'hFFFFFF : 24'h000000;
            end
        end
    end

endmodule

// File: doc/bin_median3x3.md
Name: bin_median3x3

Overview:
- Sits between the YCbCr-to-binary stage and the centroid/visualisation stages of the video pipeline.
- Removes salt-and-pepper noise from the binary mask with a 3x3 majority (median) filter before the centroid is computed.
- Takes a pixel stream with de/h_sync/v_sync and returns a filtered mask stream with re-aligned sync signals.
- Builds its line delays from the full line period, including blanking, so sync and data stay aligned by construction.

Parameters:
- H_SIZE, 1650: total clocks per video line including blanking; sets the line-delay depth.
- MASK_BIT, 0: index of the pixel_in bit that carries the binary mask.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- de_in  in  1  data enable
- h_sync_in  in  1  horizontal sync; polarity passed through unchanged
- v_sync_in  in  1  vertical sync; polarity passed through unchanged
- pixel_in  in  24  input pixel; only bit MASK_BIT is used
- de_out  out  1  delayed de
- h_sync_out  out  1  delayed h_sync
- v_sync_out  out  1  delayed v_sync
- pixel_out  out  24  24'hFFFFFF if the filtered mask is 1, else 24'h000000

Behaviour:
- Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: de_out=0, h_sync_out=0, v_sync_out=0, pixel_out=0; all window/pipeline registers, address pointer and warm-up counter cleared.
- Line-buffer RAM contents are not cleared by reset.
- Sample definition: s(t) = pixel_in[MASK_BIT] & de_in at clock t. Samples with de_in=0 count as 0.
- Latency: L = H_SIZE+2 clocks, pin to pin, fixed.
- Output at cycle t+L:
  - de_out/h_sync_out/v_sync_out equal de_in/h_sync_in/v_sync_in at cycle t.
  - Filtered mask = 1 iff at least 5 of the 9 samples s(t+dy*H_SIZE+dx), dx,dy in {-1,0,1}, are 1.
  - If de_in(t)=0, pixel_out=0 regardless of the window.
- Frame edges: neighbours fall in blanking and count as 0. No special edge logic.
- Structure:
  - Two line delays of H_SIZE-2 entries each, as dual-port RAM or SRL, sharing one write/read pointer. The pointer increments every clock and wraps from H_SIZE-3 to 0.
  - Each RAM row carries {de,hs,vs,s} for the centre row and {s} for the others.
  - A 3x3 window register; a popcount stage (4-bit sum of 9); a compare >=5; an output register.
- Warm-up:
  - After rst deasserts, a counter runs from 0 to L-1.
  - While it is counting, all outputs are forced to 0 (line-buffer contents are stale).
  - Once it reaches L-1 it saturates and outputs go live.
- Reset mid-frame: outputs drop to 0 immediately (asynchronous). The warm-up restarts on deassert. No partial-frame recovery is attempted; the first clean frame after warm-up is correct.
- No backpressure; one sample per clock, continuous.

Optional Feature:
- Macro: BIN_MORPH_MODE_EN.
- When defined:
  - Adds input port mode [1:0], sampled every clock and pipelined alongside the data so a change takes effect on the sample entering that clock.
  - Threshold on the 9-sample popcount by mode:
    - 0: median, >=5
    - 1: erosion, all 9 = 1
    - 2: dilation, at least 1
    - 3: bypass, centre sample only
  - Latency L is unchanged for every mode.
- When not defined: no mode port; median only.

Test Plan (bench uses H_SIZE=16, 10 active columns, 8 active rows, 6 blanking clocks/line, 2 blanking lines):
1. rst held 5 clocks, then released with de_in=1 continuous -> all outputs 0 during reset and for the first 18 clocks after release; de_out follows de_in from clock 18.
2. All-zero frame with a single 1 at (row 3, col 4) -> pixel_out 0 for the whole frame (isolated pixel removed).
3. Solid 3x3 block of ones at rows 2-4, cols 3-5 -> pixel_out 24'hFFFFFF exactly at (3,4), (2,4), (4,4), (3,3), (3,5) (plus shape); the four block corners and all else 0.
4. Full-white frame -> every active pixel white except the four frame corners (only 4 neighbours active -> 0); edge pixels white (6 ones).
5. h_sync_in pulse of 3 clocks starting at cycle T, v_sync_in asserted for one line -> h_sync_out pulse starts at T+18, same width; v_sync_out equally delayed by 18; polarity preserved.
6. rst asserted mid-line in frame 1 -> outputs 0 in the same cycle; after release and 18 warm-up clocks, frame 2 matches scenario 3 results bit-exact. With BIN_MORPH_MODE_EN and mode=1 on the scenario-3 block -> only (3,4) white; mode=2 -> rows 1-5, cols 2-6 white.
